axil_resp_regs: RTL and testbench
=================================

Name: axil_resp_regs

Overview:
- AXI4-Lite responder (subordinate) holding a bank of 32-bit registers. It is the far end of the AXI-Lite stimulus master used in the MCDMA benches.
- Stands in for an MCDMA register space or a descriptor BRAM when the bench runs the master against a known-good target.
- Independent write and read channel FSMs, byte-strobe writes, out-of-range decode to SLVERR, and programmable ready back-pressure so master handshake corner cases can be exercised.

Parameters:
- DATA_WIDTH, 32, data bus width; only 32 is supported.
- ADDR_WIDTH, 32, address bus width.
- NUM_REGS, 64, number of 32-bit words; power of two, range 2..1024.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to 4*NUM_REGS.
- READY_DELAY, 0, cycles a VALID must be held before the matching READY rises; range 0..15.

Ports:
- S_AXI_aclk  in  1  clock.
- S_AXI_areset  in  1  asynchronous reset, active-high.
- S_AXI_awaddr  in  ADDR_WIDTH  write address.
- S_AXI_awprot  in  3  ignored.
- S_AXI_awvalid  in  1  write address valid.
- S_AXI_awready  out  1  write address ready.
- S_AXI_wdata  in  DATA_WIDTH  write data.
- S_AXI_wstrb  in  DATA_WIDTH/8  byte enables.
- S_AXI_wvalid  in  1  write data valid.
- S_AXI_wready  out  1  write data ready.
- S_AXI_bresp  out  2  write response: OKAY=0, SLVERR=2.
- S_AXI_bvalid  out  1  write response valid.
- S_AXI_bready  in  1  write response ready.
- S_AXI_araddr  in  ADDR_WIDTH  read address.
- S_AXI_arprot  in  3  ignored.
- S_AXI_arvalid  in  1  read address valid.
- S_AXI_arready  out  1  read address ready.
- S_AXI_rdata  out  DATA_WIDTH  read data.
- S_AXI_rresp  out  2  read response.
- S_AXI_rvalid  out  1  read data valid.
- S_AXI_rready  in  1  read data ready.
- wr_commit  out  1  one-cycle pulse when a write is committed to the bank.
- wr_index  out  log2(NUM_REGS)  word index of the last commit; held between commits.

Behaviour:
- Reset: every output is 0, every register is 0, both FSMs go to IDLE, delay counters clear. Reset asserted mid-transaction abandons it: no B/R beat is issued afterwards and register contents return to 0.
- Address decode:
  - off = addr - BASE_ADDR; in range when off < 4*NUM_REGS.
  - idx = off[2 +: log2(NUM_REGS)]; addr[1:0] is ignored.
  - Out of range: SLVERR, write discarded, rdata = 32'hDEAD_BEEF.
- Write FSM states: W_IDLE, W_RESP.
  - In W_IDLE, AW and W are captured independently, in either order or the same cycle, into aw_held/w_held.
  - awready is high only while !aw_held and the AW delay has expired. wready follows the same rule with w_held and the W delay.
  - When both are held (including the capture cycle itself), the write commits on the next edge: each byte k with wstrb[k]=1 updates byte k of reg[idx]. wr_commit pulses on that edge for in-range writes only.
  - bvalid rises on that same edge, so B follows the last of AW/W by 1 cycle. FSM moves to W_RESP; the held flags clear.
  - W_RESP: bvalid and bresp stable until bready; return to W_IDLE on the handshake edge. awready and wready are low in W_RESP, so one write is outstanding at a time.
- Read FSM states: R_IDLE, R_RESP.
  - arready is high in R_IDLE once the AR delay has expired.
  - On AR handshake, rdata/rresp are registered from the current array contents and rvalid rises the next cycle (1-cycle latency).
  - R_RESP: rvalid, rdata and rresp stable until rready; return to R_IDLE on the handshake edge.
- Delay rule:
  - READY_DELAY=0: READY is high whenever the channel can accept, so ready-before-valid occurs.
  - READY_DELAY=N: the per-channel counter counts cycles with VALID high. READY rises in the cycle after VALID has been seen for N cycles, drops after the handshake, and the counter clears.
- Same-cycle read and write commit to the same idx: the read returns the pre-write value; the write still commits.
- Multiple writes to one register: last committed value wins. wstrb=0 commits nothing to the register but still pulses wr_commit and returns OKAY.

Decomposition:
- Package axil_resp_pkg: resp_t enum (OKAY=2'b00, SLVERR=2'b10), w_state_t, r_state_t, the DEAD_BEEF constant, and an idx_w function (clog2).
- One sub-module, axil_ready_dly: the VALID-count/READY generator, instantiated three times (AW, W, AR).

Test Plan:
- READY_DELAY=0: write 32'h1234_5678 to 0x10, read 0x10 -> OKAY, rdata 32'h1234_5678; wr_commit pulses once with wr_index=4.
- W valid 3 cycles before AW, then AW and W in the same cycle -> single commit each; bvalid exactly 1 cycle after the later capture.
- wstrb=4'b0101 with 32'hAABB_CCDD onto 32'h1122_3344 -> readback 32'h11BB_33DD.
- Addr 4*NUM_REGS (0x100 at defaults), write and read -> both SLVERR, read data 32'hDEAD_BEEF, wr_commit stays 0, reg 0 unchanged.
- READY_DELAY=3, bready/rready held low 5 cycles -> READY rises after 3 VALID cycles; bvalid/rvalid and data stable until accepted; no second AW accepted meanwhile.
- Assert reset while in W_RESP -> bvalid drops immediately, registers read 0 after release, next write completes normally.

Source files
------------

// File: rtl/axil_resp_pkg.sv
// Shared types and constants for the AXI4-Lite register responder.
package axil_resp_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } r_state_t;

  // Returned on reads that fall outside the register window.
  localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;

  // Width of a word index into a bank of n registers.
  function automatic int unsigned idx_w(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/axil_ready_dly.sv
// READY generator: READY asserts once VALID has been seen for DELAY
// cycles while the channel can accept, and re-arms after each handshake.
module axil_ready_dly #(
  parameter int unsigned DELAY = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic valid,
  input  logic enable,
  output logic ready
);

  logic [3:0] cnt;
  logic       alive;
  logic       expired;

  // Counter saturates at DELAY, so equality marks the delay as elapsed.
  always_comb begin
    expired = (cnt == 4'(DELAY));
    ready   = alive && enable && expired;
  end

  // Count VALID cycles while accepting; clear on handshake. alive keeps
  // READY low while reset is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      alive <= 1'b0;
    end else begin
      alive <= 1'b1;
      if (valid && ready)
        cnt <= '0;
      else if (valid && enable && !expired)
        cnt <= cnt + 4'd1;
    end
  end

endmodule

// File: rtl/axil_resp_regs.sv
// AXI4-Lite responder with a bank of 32-bit registers, byte-strobe writes,
// SLVERR on out-of-window accesses and programmable READY back-pressure.
module axil_resp_regs
  import axil_resp_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           NUM_REGS    = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned           READY_DELAY = 0
) (
  input  logic                        S_AXI_aclk,
  input  logic                        S_AXI_areset,
  input  logic [ADDR_WIDTH-1:0]       S_AXI_awaddr,
  input  logic [2:0]                  S_AXI_awprot,
  input  logic                        S_AXI_awvalid,
  output logic                        S_AXI_awready,
  input  logic [DATA_WIDTH-1:0]       S_AXI_wdata,
  input  logic [DATA_WIDTH/8-1:0]     S_AXI_wstrb,
  input  logic                        S_AXI_wvalid,
  output logic                        S_AXI_wready,
  output logic [1:0]                  S_AXI_bresp,
  output logic                        S_AXI_bvalid,
  input  logic                        S_AXI_bready,
  input  logic [ADDR_WIDTH-1:0]       S_AXI_araddr,
  input  logic [2:0]                  S_AXI_arprot,
  input  logic                        S_AXI_arvalid,
  output logic                        S_AXI_arready,
  output logic [DATA_WIDTH-1:0]       S_AXI_rdata,
  output logic [1:0]                  S_AXI_rresp,
  output logic                        S_AXI_rvalid,
  input  logic                        S_AXI_rready,
  output logic                        wr_commit,
  output logic [idx_w(NUM_REGS)-1:0]  wr_index
);

  localparam int unsigned           IW   = idx_w(NUM_REGS);
  localparam int unsigned           NB   = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(4 * NUM_REGS);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  w_state_t w_state, w_state_nx;
  r_state_t r_state, r_state_nx;

  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [NB-1:0]         w_strb_q;

  logic                  aw_en, w_en, ar_en;
  logic                  aw_hs, w_hs, ar_hs, wr_fire;
  logic [ADDR_WIDTH-1:0] wr_addr, wr_off, rd_off;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NB-1:0]         wr_strb;
  logic [IW-1:0]         wr_idx, rd_idx;
  logic                  wr_in, rd_in;
  logic                  unused_bits;

  // Handshakes, and the effective write beat: a channel captured this very
  // cycle is taken straight from the bus so commit needs no extra cycle.
  always_comb begin
    aw_en   = (w_state == W_IDLE) && !aw_held;
    w_en    = (w_state == W_IDLE) && !w_held;
    ar_en   = (r_state == R_IDLE);
    aw_hs   = S_AXI_awvalid && S_AXI_awready;
    w_hs    = S_AXI_wvalid && S_AXI_wready;
    ar_hs   = S_AXI_arvalid && S_AXI_arready;
    wr_fire = (w_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);
    wr_addr = aw_held ? aw_addr_q : S_AXI_awaddr;
    wr_data = w_held ? w_data_q : S_AXI_wdata;
    wr_strb = w_held ? w_strb_q : S_AXI_wstrb;
    wr_off  = wr_addr - BASE_ADDR;
    wr_in   = (wr_off < SPAN);
    wr_idx  = wr_off[2 +: IW];
    rd_off  = S_AXI_araddr - BASE_ADDR;
    rd_in   = (rd_off < SPAN);
    rd_idx  = rd_off[2 +: IW];
    unused_bits = ^{S_AXI_awprot, S_AXI_arprot, wr_off, rd_off};
  end

  axil_ready_dly #(.DELAY(READY_DELAY)) u_aw_dly (
    .clk(S_AXI_aclk), .rst(S_AXI_areset),
    .valid(S_AXI_awvalid), .enable(aw_en), .ready(S_AXI_awready)
  );

  axil_ready_dly #(.DELAY(READY_DELAY)) u_w_dly (
    .clk(S_AXI_aclk), .rst(S_AXI_areset),
    .valid(S_AXI_wvalid), .enable(w_en), .ready(S_AXI_wready)
  );

  axil_ready_dly #(.DELAY(READY_DELAY)) u_ar_dly (
    .clk(S_AXI_aclk), .rst(S_AXI_areset),
    .valid(S_AXI_arvalid), .enable(ar_en), .ready(S_AXI_arready)
  );

  // Channel FSM state registers.
  always_ff @(posedge S_AXI_aclk or posedge S_AXI_areset) begin
    if (S_AXI_areset) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_state_nx;
      r_state <= r_state_nx;
    end
  end

  // Write FSM next state; bvalid is simply "in W_RESP".
  always_comb begin
    w_state_nx   = w_state;
    S_AXI_bvalid = 1'b0;
    case (w_state)
      W_IDLE: if (wr_fire) w_state_nx = W_RESP;
      W_RESP: begin
        S_AXI_bvalid = 1'b1;
        if (S_AXI_bready) w_state_nx = W_IDLE;
      end
      default: w_state_nx = W_IDLE;
    endcase
  end

  // Read FSM next state; rvalid is simply "in R_RESP".
  always_comb begin
    r_state_nx   = r_state;
    S_AXI_rvalid = 1'b0;
    case (r_state)
      R_IDLE: if (ar_hs) r_state_nx = R_RESP;
      R_RESP: begin
        S_AXI_rvalid = 1'b1;
        if (S_AXI_rready) r_state_nx = R_IDLE;
      end
      default: r_state_nx = R_IDLE;
    endcase
  end

  // Write path: hold AW/W independently, commit strobed bytes once both
  // are present, and latch the response.
  always_ff @(posedge S_AXI_aclk or posedge S_AXI_areset) begin
    if (S_AXI_areset) begin
      aw_held     <= 1'b0;
      w_held      <= 1'b0;
      aw_addr_q   <= '0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      S_AXI_bresp <= OKAY;
      wr_commit   <= 1'b0;
      wr_index    <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_commit <= 1'b0;
      if (wr_fire) begin
        aw_held     <= 1'b0;
        w_held      <= 1'b0;
        S_AXI_bresp <= wr_in ? OKAY : SLVERR;
        if (wr_in) begin
          wr_commit <= 1'b1;
          wr_index  <= wr_idx;
          for (int unsigned k = 0; k < NB; k++)
            if (wr_strb[k]) regs[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
        end
      end else begin
        if (aw_hs) begin
          aw_held   <= 1'b1;
          aw_addr_q <= S_AXI_awaddr;
        end
        if (w_hs) begin
          w_held   <= 1'b1;
          w_data_q <= S_AXI_wdata;
          w_strb_q <= S_AXI_wstrb;
        end
      end
    end
  end

  // Read path: sample the bank on the AR handshake (pre-write value when a
  // commit lands on the same edge).
  always_ff @(posedge S_AXI_aclk or posedge S_AXI_areset) begin
    if (S_AXI_areset) begin
      S_AXI_rdata <= '0;
      S_AXI_rresp <= OKAY;
    end else if (ar_hs) begin
      S_AXI_rdata <= rd_in ? regs[rd_idx] : DEAD_BEEF;
      S_AXI_rresp <= rd_in ? OKAY : SLVERR;
    end
  end

endmodule

// File: tb/tb_axil_resp_regs.sv
// Directed bench for axil_resp_regs: one instance with no READY delay,
// one with READY_DELAY=3.
module tb_axil_resp_regs;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] prot = '0;

  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready, wready, bvalid, arready, rvalid, wr_commit;
  logic [1:0]  bresp, rresp;
  logic [5:0]  wr_index;

  logic [31:0] awaddr3, wdata3, araddr3, rdata3;
  logic [3:0]  wstrb3;
  logic        awvalid3, wvalid3, bready3, arvalid3, rready3;
  logic        awready3, wready3, bvalid3, arready3, rvalid3, wr_commit3;
  logic [1:0]  bresp3, rresp3;
  logic [5:0]  wr_index3;

  int n_vec = 0;
  int n_bad = 0;
  int n_commit0 = 0;
  int n_commit3 = 0;

  always #5 clk = ~clk;

  axil_resp_regs #(.READY_DELAY(0)) u_dut0 (
    .S_AXI_aclk(clk), .S_AXI_areset(rst),
    .S_AXI_awaddr(awaddr), .S_AXI_awprot(prot), .S_AXI_awvalid(awvalid), .S_AXI_awready(awready),
    .S_AXI_wdata(wdata), .S_AXI_wstrb(wstrb), .S_AXI_wvalid(wvalid), .S_AXI_wready(wready),
    .S_AXI_bresp(bresp), .S_AXI_bvalid(bvalid), .S_AXI_bready(bready),
    .S_AXI_araddr(araddr), .S_AXI_arprot(prot), .S_AXI_arvalid(arvalid), .S_AXI_arready(arready),
    .S_AXI_rdata(rdata), .S_AXI_rresp(rresp), .S_AXI_rvalid(rvalid), .S_AXI_rready(rready),
    .wr_commit(wr_commit), .wr_index(wr_index)
  );

  axil_resp_regs #(.READY_DELAY(3)) u_dut3 (
    .S_AXI_aclk(clk), .S_AXI_areset(rst),
    .S_AXI_awaddr(awaddr3), .S_AXI_awprot(prot), .S_AXI_awvalid(awvalid3), .S_AXI_awready(awready3),
    .S_AXI_wdata(wdata3), .S_AXI_wstrb(wstrb3), .S_AXI_wvalid(wvalid3), .S_AXI_wready(wready3),
    .S_AXI_bresp(bresp3), .S_AXI_bvalid(bvalid3), .S_AXI_bready(bready3),
    .S_AXI_araddr(araddr3), .S_AXI_arprot(prot), .S_AXI_arvalid(arvalid3), .S_AXI_arready(arready3),
    .S_AXI_rdata(rdata3), .S_AXI_rresp(rresp3), .S_AXI_rvalid(rvalid3), .S_AXI_rready(rready3),
    .wr_commit(wr_commit3), .wr_index(wr_index3)
  );

  // Count commit pulses (each is one cycle wide).
  always @(posedge clk) begin
    if (wr_commit === 1'b1) n_commit0++;
    if (wr_commit3 === 1'b1) n_commit3++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output bit ok);
    bit aw_done, w_done;
    aw_done = 1'b0; w_done = 1'b0; ok = 1'b0; resp = 2'bxx;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    for (int i = 0; i < 30 && !(aw_done && w_done); i++) begin
      @(negedge clk);
      if (awvalid && awready) aw_done = 1'b1;
      if (wvalid && wready) w_done = 1'b1;
      @(posedge clk); #1;
      if (aw_done) awvalid = 1'b0;
      if (w_done) wvalid = 1'b0;
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bvalid) begin resp = bresp; ok = aw_done && w_done; break; end
    end
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                         output bit ok);
    bit ar_done;
    ar_done = 1'b0; ok = 1'b0; d = 'x; resp = 2'bxx;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    for (int i = 0; i < 30 && !ar_done; i++) begin
      @(negedge clk);
      if (arready) ar_done = 1'b1;
      @(posedge clk); #1;
      if (ar_done) arvalid = 1'b0;
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rvalid) begin d = rdata; resp = rresp; ok = ar_done; break; end
    end
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    bit          ok, bad, aw_ok, w_ok;
    int          c0;

    {awaddr, wdata, wstrb, awvalid, wvalid, bready, araddr, arvalid, rready} = '0;
    {awaddr3, wdata3, wstrb3, awvalid3, wvalid3, bready3, araddr3, arvalid3, rready3} = '0;

    // Reset state
    @(posedge clk); #1;
    chk("rst_ctl0", 32'({awready, wready, bvalid, arready, rvalid, wr_commit, bresp, rresp}), 32'd0);
    chk("rst_rdata0", rdata, 32'd0);
    chk("rst_index0", 32'(wr_index), 32'd0);
    chk("rst_ctl3", 32'({awready3, wready3, bvalid3, arready3, rvalid3, wr_commit3, bresp3, rresp3}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic write/read at 0x10
    c0 = n_commit0;
    do_write(32'h10, 32'h1234_5678, 4'hF, r, ok);
    chk("t1_wr_done", 32'(ok), 32'd1);
    chk("t1_bresp", 32'(r), 32'd0);
    chk("t1_commits", 32'(n_commit0 - c0), 32'd1);
    chk("t1_index", 32'(wr_index), 32'd4);
    do_read(32'h10, d, r, ok);
    chk("t1_rd_done", 32'(ok), 32'd1);
    chk("t1_rresp", 32'(r), 32'd0);
    chk("t1_rdata", d, 32'h1234_5678);
    do_read(32'h13, d, r, ok);
    chk("lowbits_rdata", d, 32'h1234_5678);

    // W three cycles ahead of AW
    @(posedge clk); #1;
    c0 = n_commit0; bad = 1'b0;
    awaddr = 32'h20; wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    chk("wf_wready", 32'(wready), 32'd1);
    @(posedge clk); #1;
    wvalid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (wready || bvalid || wr_commit) bad = 1'b1;
      @(posedge clk); #1;
    end
    chk("wf_hold", 32'(bad), 32'd0);
    awvalid = 1'b1;
    @(negedge clk);
    chk("wf_awready", 32'(awready), 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    chk("wf_b_latency", 32'({bvalid, wr_commit}), 32'd3);
    chk("wf_index", 32'(wr_index), 32'd8);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    chk("wf_b_done", 32'(bvalid), 32'd0);
    chk("wf_commits", 32'(n_commit0 - c0), 32'd1);
    do_read(32'h20, d, r, ok);
    chk("wf_rdata", d, 32'hCAFE_F00D);

    // Byte strobes
    do_write(32'h14, 32'h1122_3344, 4'hF, r, ok);
    do_write(32'h14, 32'hAABB_CCDD, 4'b0101, r, ok);
    chk("strb_bresp", 32'(r), 32'd0);
    do_read(32'h14, d, r, ok);
    chk("strb_rdata", d, 32'h11BB_33DD);

    // Empty strobe: still a commit and OKAY, register unchanged
    c0 = n_commit0;
    do_write(32'h14, 32'hFFFF_FFFF, 4'h0, r, ok);
    chk("strb0_bresp", 32'(r), 32'd0);
    chk("strb0_commits", 32'(n_commit0 - c0), 32'd1);
    chk("strb0_index", 32'(wr_index), 32'd5);
    do_read(32'h14, d, r, ok);
    chk("strb0_rdata", d, 32'h11BB_33DD);

    // Out of range at 4*NUM_REGS
    do_write(32'h0, 32'hA5A5_A5A5, 4'hF, r, ok);
    c0 = n_commit0;
    do_write(32'h100, 32'h5555_5555, 4'hF, r, ok);
    chk("oor_wr_done", 32'(ok), 32'd1);
    chk("oor_bresp", 32'(r), 32'd2);
    chk("oor_commits", 32'(n_commit0 - c0), 32'd0);
    chk("oor_index", 32'(wr_index), 32'd0);
    do_read(32'h100, d, r, ok);
    chk("oor_rresp", 32'(r), 32'd2);
    chk("oor_rdata", d, 32'hDEAD_BEEF);
    do_read(32'h0, d, r, ok);
    chk("oor_reg0", d, 32'hA5A5_A5A5);
    do_read(32'hFC, d, r, ok);
    chk("top_word_rresp", 32'(r), 32'd0);
    chk("top_word_rdata", d, 32'd0);

    // Same-edge read and write to one register: read sees the old value
    @(posedge clk); #1;
    awaddr = 32'h10; wdata = 32'h8765_4321; wstrb = 4'hF; araddr = 32'h10;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(negedge clk);
    chk("sc_ready", 32'({awready, wready, arready}), 32'd7);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("sc_valids", 32'({bvalid, rvalid, wr_commit}), 32'd7);
    chk("sc_rdata_old", rdata, 32'h1234_5678);
    bready = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0; rready = 1'b0;
    do_read(32'h10, d, r, ok);
    chk("sc_rdata_new", d, 32'h8765_4321);

    // READY_DELAY=3 write with B back-pressure
    @(posedge clk); #1;
    awaddr3 = 32'h8; wdata3 = 32'h0BAD_F00D; wstrb3 = 4'hF; awvalid3 = 1'b1; wvalid3 = 1'b1;
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (awready3 || wready3) bad = 1'b1;
      @(posedge clk); #1;
    end
    chk("d3_aw_early", 32'(bad), 32'd0);
    @(negedge clk);
    chk("d3_aw_ready", 32'({awready3, wready3}), 32'd3);
    @(posedge clk); #1;
    chk("d3_b_rise", 32'({bvalid3, wr_commit3}), 32'd3);
    awaddr3 = 32'hC; wdata3 = 32'h600D_CAFE;
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (awready3 || wready3 || !bvalid3 || bresp3 !== 2'b00) bad = 1'b1;
      @(posedge clk); #1;
    end
    chk("d3_b_hold", 32'(bad), 32'd0);
    bready3 = 1'b1;
    @(posedge clk); #1;
    bready3 = 1'b0;
    chk("d3_b_done", 32'(bvalid3), 32'd0);
    aw_ok = 1'b0; w_ok = 1'b0;
    for (int i = 0; i < 12 && !(aw_ok && w_ok); i++) begin
      @(negedge clk);
      if (awready3) aw_ok = 1'b1;
      if (wready3) w_ok = 1'b1;
      @(posedge clk); #1;
      if (aw_ok) awvalid3 = 1'b0;
      if (w_ok) wvalid3 = 1'b0;
    end
    chk("d3_second_accept", 32'({aw_ok, w_ok}), 32'd3);
    chk("d3_second_b", 32'(bvalid3), 32'd1);
    bready3 = 1'b1;
    @(posedge clk); #1;
    bready3 = 1'b0;
    chk("d3_commits", 32'(n_commit3), 32'd2);
    chk("d3_index", 32'(wr_index3), 32'd3);

    // READY_DELAY=3 read with R back-pressure
    araddr3 = 32'h8; arvalid3 = 1'b1; bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (arready3) bad = 1'b1;
      @(posedge clk); #1;
    end
    chk("d3_ar_early", 32'(bad), 32'd0);
    @(negedge clk);
    chk("d3_ar_ready", 32'(arready3), 32'd1);
    @(posedge clk); #1;
    arvalid3 = 1'b0;
    chk("d3_r_rise", 32'(rvalid3), 32'd1);
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (!rvalid3 || rdata3 !== 32'h0BAD_F00D || rresp3 !== 2'b00 || arready3) bad = 1'b1;
      @(posedge clk); #1;
    end
    chk("d3_r_hold", 32'(bad), 32'd0);
    rready3 = 1'b1;
    @(posedge clk); #1;
    rready3 = 1'b0;
    chk("d3_r_done", 32'(rvalid3), 32'd0);

    // Reset while a write response is pending
    awaddr = 32'h18; wdata = 32'h5A5A_5A5A; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    chk("rs_ready", 32'({awready, wready}), 32'd3);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    chk("rs_in_resp", 32'(bvalid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rs_b_drop", 32'(bvalid), 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rs_no_b", 32'(bvalid), 32'd0);
    do_read(32'h18, d, r, ok);
    chk("rs_reg18", d, 32'd0);
    do_read(32'h10, d, r, ok);
    chk("rs_reg10", d, 32'd0);
    c0 = n_commit0;
    do_write(32'h18, 32'hC0FF_EE11, 4'hF, r, ok);
    chk("rs_wr_done", 32'(ok), 32'd1);
    chk("rs_bresp", 32'(r), 32'd0);
    chk("rs_commits", 32'(n_commit0 - c0), 32'd1);
    do_read(32'h18, d, r, ok);
    chk("rs_rdata", d, 32'hC0FF_EE11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
